// File: rtl/fp_div.sv
// fp_div: iterative FP32 divider, restoring division, one quotient bit per
// cycle, truncated result. Ports: clk, rst_n, start, data_1 (dividend),
// data_2 (divisor), data_quot (quotient), busy, done (one-cycle pulse).
module fp_div #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_1,
  input  logic [DATA_WIDTH-1:0] data_2,
  output logic [DATA_WIDTH-1:0] data_quot,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    NORM
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] rem_q, rem_d;
  logic [24:0] dvs_q, dvs_d;
  logic [24:0] quo_q, quo_d;
  logic [9:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        zdiv_q, zdiv_d;
  logic        znum_q, znum_d;
  logic [31:0] quot_q, quot_d;
  logic        done_q, done_d;

  logic [24:0] diff;
  logic [24:0] r_sel;
  logic        ge;
  logic [9:0]  e_n;
  logic [22:0] mant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      exp_q   <= '0;
      sign_q  <= 1'b0;
      zdiv_q  <= 1'b0;
      znum_q  <= 1'b0;
      quot_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      exp_q   <= exp_d;
      sign_q  <= sign_d;
      zdiv_q  <= zdiv_d;
      znum_q  <= znum_d;
      quot_q  <= quot_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    exp_d   = exp_q;
    sign_d  = sign_q;
    zdiv_d  = zdiv_q;
    znum_d  = znum_q;
    quot_d  = quot_q;
    done_d  = 1'b0;

    ge    = (rem_q >= dvs_q);
    diff  = rem_q - dvs_q;
    r_sel = ge ? diff : rem_q;
    // Q[24] set means the quotient is in [1,2); else the
    // leading one sits at Q[23] and the exponent drops by one.
    e_n   = quo_q[24] ? exp_q : exp_q - 10'd1;
    mant  = quo_q[24] ? quo_q[23:1] : quo_q[22:0];

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CALC;
          cnt_d   = '0;
          sign_d  = data_1[31] ^ data_2[31];
          exp_d   = {2'b00, data_1[30:23]}
                  - {2'b00, data_2[30:23]}
                  + 10'd127;
          rem_d   = {2'b01, data_1[22:0]};
          dvs_d   = {2'b01, data_2[22:0]};
          quo_d   = '0;
          zdiv_d  = (data_2[30:23] == 8'h00);
          znum_d  = (data_1[30:23] == 8'h00);
        end
      end
      CALC: begin
        // Remainder stays below 2*D, so the shift never drops a one.
        rem_d = {r_sel[23:0], 1'b0};
        quo_d = {quo_q[23:0], ge};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24) state_d = NORM;
      end
      NORM: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (zdiv_q)
          quot_d = {sign_q, 8'hFF, 23'h0};
        else if (znum_q)
          quot_d = {sign_q, 31'h0};
        else if ($signed(e_n) >= 10'sd255)
          quot_d = {sign_q, 8'hFF, 23'h0};
        else if ($signed(e_n) <= 10'sd0)
          quot_d = {sign_q, 31'h0};
        else
          quot_d = {sign_q, e_n[7:0], mant};
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_quot = quot_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
